// File: rtl/uart_rx_os_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os_if
// Brief    : Byte handshake between the UART receiver and the console registers
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 rx_ack;
    logic                 framing_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_ready,
        output framing_err,
        output overrun_err,
        output busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        input  framing_err,
        input  overrun_err,
        input  busy,
        output rx_ack
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Brief    : 8N1 UART receiver on a 16x oversampling tick, ready/ack byte output
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  wire               clk,
    input  wire               reset,
    input  wire               rx_baud_clk,
    input  wire               rxd,
    uart_rx_os_if.master      rx_bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic                 r_rxd_meta;
    logic                 r_rxd_s;
    logic                 r_baud_q;
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bitidx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_ready;
    logic                 r_framing_err;
    logic                 r_overrun_err;
    logic                 w_busy;
    logic                 w_tick;
    logic                 w_cnt_wrap;
    logic                 w_done;
    logic                 w_ack_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_baud_q   <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
            r_baud_q   <= rx_baud_clk;
        end
    end

    assign w_tick     = rx_baud_clk & ~r_baud_q;
    assign w_cnt_wrap = w_tick && (r_cnt == c_cnt_last);
    assign w_done     = (r_state == c_st_stop) && w_cnt_wrap;
    assign w_ack_hit  = rx_bus.rx_ack & r_rx_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_tick && !r_rxd_s) begin
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_tick && (r_cnt == c_cnt_half)) begin
                    w_state_next = r_rxd_s ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (w_cnt_wrap && (r_bitidx == c_bit_last)) begin
                    w_state_next = c_st_stop;
                end
            end
            default: begin
                if (w_cnt_wrap) begin
                    w_state_next = c_st_idle;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = (r_state != c_st_idle);
    end

    // Sample counters and shift register, all advanced by tick only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_bitidx <= '0;
            r_shreg  <= '0;
        end else if (w_tick) begin
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                end
                c_st_start: begin
                    if (r_cnt == c_cnt_half) begin
                        r_cnt    <= '0;
                        r_bitidx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_shreg <= {r_rxd_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bitidx != c_bit_last) begin
                            r_bitidx <= r_bitidx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
                end
            endcase
        end
    end

    // A completing byte takes priority over an ack landing in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data     <= '0;
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (w_done) begin
            r_rx_data     <= r_shreg;
            r_rx_ready    <= 1'b1;
            r_framing_err <= ~r_rxd_s;
            r_overrun_err <= w_ack_hit ? 1'b0 : (r_overrun_err | r_rx_ready);
        end else if (w_ack_hit) begin
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end
    end

    assign rx_bus.rx_data     = r_rx_data;
    assign rx_bus.rx_ready    = r_rx_ready;
    assign rx_bus.framing_err = r_framing_err;
    assign rx_bus.overrun_err = r_overrun_err;
    assign rx_bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Brief    : Directed self-checking bench for uart_rx_os
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int BAUD_DIV = 8;

    logic clk = 1'b0;
    logic reset;
    logic rx_baud_clk;
    logic rxd;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_os_if #(.DATA_BITS(DB)) bus ();

    uart_rx_os #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_baud_clk (rx_baud_clk),
        .rxd         (rxd),
        .rx_bus      (bus)
    );

    always #5 clk = ~clk;

    // Baud square wave, 8 clk period, changes on the falling clk edge
    initial begin : baud_gen
        int b;
        b = 0;
        rx_baud_clk = 1'b0;
        forever begin
            @(negedge clk);
            b = (b + 1) % BAUD_DIV;
            rx_baud_clk = (b < BAUD_DIV / 2);
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge rx_baud_clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
    endtask

    // Line time: start at T0, stop bit at T144, DUT completes on tick T153
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit ack_at_done);
        logic [7:0] v;
        v   = d;
        rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) begin
            rxd = v[i];
            wait_ticks(OS);
        end
        rxd = stop_bit;
        if (ack_at_done) begin
            wait_ticks(OS / 2 + 1);
            bus.rx_ack = 1'b1;
            @(negedge clk);
            bus.rx_ack = 1'b0;
            wait_ticks(OS - (OS / 2 + 1));
        end else begin
            wait_ticks(OS);
        end
        rxd = 1'b1;
    endtask

    initial begin : main
        int k;
        reset      = 1'b1;
        rxd        = 1'b1;
        bus.rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data",  bus.rx_data,     32'h0);
        check_eq("rst_ready", bus.rx_ready,    32'h0);
        check_eq("rst_fe",    bus.framing_err, 32'h0);
        check_eq("rst_oe",    bus.overrun_err, 32'h0);
        check_eq("rst_busy",  bus.busy,        32'h0);
        reset = 1'b0;
        wait_ticks(4);

        // Frame 0xC3 interrupted by reset at tick 60
        rxd = 1'b0; wait_ticks(16);
        rxd = 1'b1; wait_ticks(16);
        rxd = 1'b1; wait_ticks(16);
        rxd = 1'b0; wait_ticks(12);
        check_eq("mid_busy_before", bus.busy, 32'h1);
        reset = 1'b1;
        #1;
        check_eq("mid_busy",  bus.busy,        32'h0);
        check_eq("mid_ready", bus.rx_ready,    32'h0);
        check_eq("mid_data",  bus.rx_data,     32'h0);
        check_eq("mid_fe",    bus.framing_err, 32'h0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ticks(4);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_eq("post_rst_data",  bus.rx_data,     32'h3C);
        check_eq("post_rst_ready", bus.rx_ready,    32'h1);
        check_eq("post_rst_fe",    bus.framing_err, 32'h0);
        do_ack();
        check_eq("post_rst_ack", bus.rx_ready, 32'h0);

        // Basic 0x55 with start-detect to ready latency of 152 ticks
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                k = 0;
                while (!bus.busy && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                check_eq("basic_busy", bus.busy, 32'h1);
                k = 0;
                while (!bus.rx_ready && k < 3000) begin
                    @(negedge clk);
                    k++;
                end
                check_eq("basic_latency_clk", k, 152 * BAUD_DIV);
            end
        join
        check_eq("basic_data",  bus.rx_data,     32'h55);
        check_eq("basic_ready", bus.rx_ready,    32'h1);
        check_eq("basic_fe",    bus.framing_err, 32'h0);
        do_ack();
        check_eq("basic_ack", bus.rx_ready, 32'h0);

        // Short low glitch must be rejected at the start check
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(4);
        check_eq("glitch_busy", bus.busy, 32'h1);
        rxd = 1'b1;
        wait_ticks(20);
        check_eq("glitch_idle",  bus.busy,     32'h0);
        check_eq("glitch_ready", bus.rx_ready, 32'h0);

        // Stop bit low still delivers the byte
        send_frame(8'hA5, 1'b0, 1'b0);
        check_eq("fe_data",  bus.rx_data,     32'hA5);
        check_eq("fe_ready", bus.rx_ready,    32'h1);
        check_eq("fe_flag",  bus.framing_err, 32'h1);
        wait_ticks(20);
        check_eq("fe_idle", bus.busy, 32'h0);
        do_ack();
        check_eq("fe_ack_ready", bus.rx_ready,    32'h0);
        check_eq("fe_ack_flag",  bus.framing_err, 32'h0);

        // Break: line held low through the stop bit
        rxd = 1'b0;
        wait_ticks(156);
        check_eq("brk_data",  bus.rx_data,     32'h00);
        check_eq("brk_ready", bus.rx_ready,    32'h1);
        check_eq("brk_fe",    bus.framing_err, 32'h1);
        rxd = 1'b1;
        wait_ticks(20);
        check_eq("brk_idle", bus.busy, 32'h0);
        do_ack();

        // Back-to-back without ack -> overrun
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check_eq("ovr_data",  bus.rx_data,     32'h34);
        check_eq("ovr_ready", bus.rx_ready,    32'h1);
        check_eq("ovr_flag",  bus.overrun_err, 32'h1);
        check_eq("ovr_fe",    bus.framing_err, 32'h0);
        do_ack();
        check_eq("ovr_ack_flag",  bus.overrun_err, 32'h0);
        check_eq("ovr_ack_ready", bus.rx_ready,    32'h0);

        // Ack coinciding with completion: new byte wins, prior overrun cleared
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0);
        check_eq("sim_pre_oe", bus.overrun_err, 32'h1);
        send_frame(8'h34, 1'b1, 1'b1);
        check_eq("sim_ready", bus.rx_ready,    32'h1);
        check_eq("sim_data",  bus.rx_data,     32'h34);
        check_eq("sim_oe",    bus.overrun_err, 32'h0);
        check_eq("sim_fe",    bus.framing_err, 32'h0);
        do_ack();
        check_eq("sim_ack", bus.rx_ready, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
